constant_addition: RTL and testbench

- ASCON permutation layer p_C: XORs the per-round constant into the low byte of state word x2; all other words pass through unchanged.
- First layer of each permutation round, ahead of the substitution and linear diffusion layers in the ASCON datapath.
- Result is registered: one-cycle latency, with a valid strobe for pipeline alignment.

---
 rtl/ascon_pack.sv | 29 ++
 rtl/constant_addition.sv | 34 +++
 tb/tb_constant_addition.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared ASCON definitions: permutation state type and round-constant lookup.
package ascon_pack;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned N_WORDS  = 5;
  localparam int unsigned RC_W     = 8;
  localparam int unsigned ROUND_W  = 4;
  localparam int unsigned N_RC     = 12;
  localparam int unsigned STATE_W  = WORD_W * N_WORDS;

  // Words [0]..[4] hold x0..x4.
  typedef logic [N_WORDS-1:0][WORD_W-1:0] type_state;

  localparam logic [RC_W-1:0] ROUND_CONST [N_RC] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // Indices 12..15 map to zero so every round code yields a defined constant.
  function automatic logic [RC_W-1:0] round_constant(input logic [ROUND_W-1:0] r);
    logic [RC_W-1:0] c;
    c = '0;
    if (r < ROUND_W'(N_RC)) begin
      c = ROUND_CONST[r];
    end
    return c;
  endfunction

endpackage

// File: rtl/constant_addition.sv
// ASCON p_C layer: XOR the round constant into the low byte of x2, registered output.
module constant_addition
  import ascon_pack::*;
(
  input  logic                 clock_i,
  input  logic                 resetb_i,
  input  logic                 valid_i,
  input  type_state            constant_add_i,
  input  logic [ROUND_W-1:0]   round_i,
  output type_state            constant_add_o,
  output logic                 valid_o
);

  type_state state_c;

  // Only x2[7:0] is touched; all other bits pass through.
  always_comb begin
    state_c    = constant_add_i;
    state_c[2] = constant_add_i[2] ^ {{(WORD_W-RC_W){1'b0}}, round_constant(round_i)};
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      constant_add_o <= '0;
      valid_o        <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        constant_add_o <= state_c;
      end
    end
  end

endmodule

// File: tb/tb_constant_addition.sv
// Randomized self-checking bench for constant_addition against an arithmetic reference model.
module tb_constant_addition;
  import ascon_pack::*;

  logic        clock_i;
  logic        resetb_i;
  logic        valid_i;
  type_state   constant_add_i;
  logic [3:0]  round_i;
  type_state   constant_add_o;
  logic        valid_o;

  int unsigned total;
  int unsigned bad;

  type_state   exp_s;
  logic        exp_v;
  type_state   base;

  constant_addition dut (
    .clock_i        (clock_i),
    .resetb_i       (resetb_i),
    .valid_i        (valid_i),
    .constant_add_i (constant_add_i),
    .round_i        (round_i),
    .constant_add_o (constant_add_o),
    .valid_o        (valid_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Constant c(r) = {15-r, r} for r < 12, else zero.
  function automatic type_state ref_add(input type_state s, input logic [3:0] r);
    type_state o;
    int        ri;
    logic [7:0] c;
    ri = int'(r);
    c  = (ri < 12) ? 8'(((15 - ri) << 4) | ri) : 8'h00;
    o  = s;
    o[2][7:0] = s[2][7:0] ^ c;
    return o;
  endfunction

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Advance one edge with current inputs and check against the model.
  task automatic tick(input string tag);
    if (valid_i) exp_s = ref_add(constant_add_i, round_i);
    exp_v = valid_i;
    @(posedge clock_i);
    #1;
    check({tag, "_state"}, constant_add_o, exp_s);
    check({tag, "_valid"}, 320'(valid_o), 320'(exp_v));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    base[0] = 64'h80400c0600000000;
    base[1] = 64'h0001020304050607;
    base[2] = 64'h08090a0b0c0d0e0f;
    base[3] = 64'h0011223344556677;
    base[4] = 64'h8899aabbccddeeff;

    // Reset held with active inputs.
    resetb_i       = 1'b0;
    valid_i        = 1'b1;
    round_i        = 4'($urandom_range(0, 15));
    constant_add_i = rand_state();
    repeat (3) @(posedge clock_i);
    #1;
    check("reset_state", constant_add_o, '0);
    check("reset_valid", 320'(valid_o), 320'(0));
    exp_s = '0;
    exp_v = 1'b0;

    resetb_i       = 1'b1;
    constant_add_i = base;
    round_i        = 4'd0;
    tick("first");
    check("first_x2", 320'(constant_add_o[2]), 320'(64'h08090a0b0c0d0eff));

    // Sweep all defined rounds back to back.
    for (int r = 0; r < 12; r++) begin
      round_i = 4'(r);
      tick($sformatf("sweep%0d", r));
      check($sformatf("sweep%0d_lo", r), 320'(constant_add_o[2][7:0]), 320'(8'(8'hFF - 8'h11 * r)));
    end

    // Out-of-range rounds pass the state through.
    for (int r = 12; r < 16; r++) begin
      round_i = 4'(r);
      tick($sformatf("oor%0d", r));
      check($sformatf("oor%0d_eq", r), constant_add_o, base);
    end

    // Hold after valid drops.
    round_i = 4'd5;
    tick("hold_cap");
    check("hold_cap_lo", 320'(constant_add_o[2][7:0]), 320'(8'hAA));
    valid_i        = 1'b0;
    constant_add_i = rand_state();
    round_i        = 4'd3;
    tick("hold1");
    tick("hold2");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      valid_i        = 1'($urandom_range(0, 3) != 0);
      round_i        = 4'($urandom_range(0, 15));
      constant_add_i = rand_state();
      tick("rand");
    end

    // Asynchronous reset between edges while output is valid.
    valid_i        = 1'b1;
    constant_add_i = rand_state();
    round_i        = 4'd7;
    tick("pre_rst");
    #2;
    resetb_i = 1'b0;
    #1;
    check("async_rst_state", constant_add_o, '0);
    check("async_rst_valid", 320'(valid_o), 320'(0));
    exp_s = '0;
    exp_v = 1'b0;
    @(negedge clock_i);
    resetb_i = 1'b1;
    valid_i  = 1'b0;
    constant_add_i = rand_state();
    tick("post_rst1");
    tick("post_rst2");
    valid_i = 1'b1;
    round_i = 4'd11;
    tick("post_rst_cap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
